handshake_rr_arbiter: RTL and testbench
=======================================

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the payload width per requester and on the output channel.
REQ-002 The block SHALL have parameter N, default 4, meaning the number of requesters (fixed at 4 in this revision); the index width is 2.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the reset: synchronous, active-high.
REQ-005 The block SHALL have port s_valid, input, N, meaning the per-requester valid.
REQ-006 The block SHALL have port s_data, input, N*DATA_W, meaning the packed payloads, with requester i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port s_last, input, N, meaning the per-requester last beat of a burst.
REQ-008 The block SHALL have port s_ready, output, N, meaning the per-requester ready.
REQ-009 The block SHALL have the following output-channel ports:
- m_valid, output, 1, meaning output valid.
- m_data, output, DATA_W, meaning output payload.
- m_last, output, 1, meaning output last.
- m_id, output, 2, meaning the source requester index.
- m_ready, input, 1, meaning downstream ready.
REQ-010 The block SHALL have the following status ports:
- busy, output, 1, meaning the state is LOCK.
- grant_id, output, 2, meaning the current owner (valid while busy).

Function
REQ-011 The block SHALL implement an FSM with two states:
- IDLE: no owner, s_ready = 0.
- LOCK: one owner holds the channel.
REQ-012 In IDLE, when any s_valid bit is 1, the block SHALL select the winner round-robin: the first set bit searching from index ptr upward, wrapping 3->0.
REQ-013 On the clock edge following that selection, the block SHALL register the winner as grant_id and enter LOCK; in IDLE with s_valid = 0, it SHALL remain in IDLE.
REQ-014 In LOCK, the block SHALL drive s_ready[grant_id] = ~m_valid | m_ready and all other s_ready bits to 0; s_ready SHALL be combinational from the registered state.
REQ-015 A transfer SHALL occur on s_valid[g] & s_ready[g]; on a transfer, the block SHALL load m_data, m_last and m_id (= g) from requester g and set m_valid = 1 on the next edge.
REQ-016 When m_valid & m_ready with no concurrent upstream transfer, the block SHALL clear m_valid on the next edge; when both occur in the same cycle, m_valid SHALL stay 1 with the new beat (full throughput, 1 beat/cycle).
REQ-017 While m_valid & ~m_ready, m_data, m_last and m_id SHALL hold their values unchanged.
REQ-018 Latency SHALL be as follows:
- s_valid rising in IDLE at cycle t gives s_ready at t+1 (output stage empty).
- First m_valid at t+2.
REQ-019 On a transfer with s_last = 1, the block SHALL return to IDLE and set ptr = grant_id + 1 (mod 4) on the same edge; exactly one bubble cycle (IDLE) SHALL separate consecutive bursts.
REQ-020 In LOCK, the owner deasserting s_valid mid-burst SHALL NOT release the grant; the block SHALL stay in LOCK until the s_last beat (no timeout).
REQ-021 Non-owner s_valid/s_data SHALL be ignored in LOCK and SHALL NOT affect ptr.
REQ-022 A single-beat burst (s_last on the first beat) SHALL occupy LOCK for exactly one transfer cycle.
REQ-023 busy SHALL be 1 exactly when the state is LOCK; grant_id SHALL be the registered owner.

Reset
REQ-024 When rst = 1 at an edge, the block SHALL set: state = IDLE, ptr = 0, grant_id = 0, m_valid = 0, m_data = 0, m_last = 0, m_id = 0.
REQ-025 While rst = 1 and in the cycle after, the block SHALL hold s_ready = 0 and busy = 0.
REQ-026 Reset asserted mid-burst or with m_valid pending SHALL discard the pending beat and the grant; the first arbitration after reset SHALL start from index 0.

Verification
REQ-027 The bench SHALL cover a single requester: s_valid = 4'b0100, 3 beats 0xA0, 0xA1, 0xA2 (last on 0xA2), m_ready = 1 -> m_data 0xA0/0xA1/0xA2 on consecutive cycles, m_id = 2, m_last only on 0xA2, first m_valid 2 cycles after s_valid.
REQ-028 The bench SHALL cover round-robin: all 4 requesters valid continuously, 1-beat bursts, from reset -> m_id sequence 0,1,2,3,0, with one idle cycle between beats.
REQ-029 The bench SHALL cover backpressure: m_ready = 0 for 5 cycles during a burst from requester 1 -> m_data/m_id stable, s_ready[1] = 0 while m_valid = 1, no beat lost or duplicated after m_ready returns.
REQ-030 The bench SHALL cover a mid-burst gap: owner 3 drops s_valid 4 cycles mid-burst while requester 0 is valid -> grant_id stays 3, busy = 1, s_ready[0] = 0 throughout.
REQ-031 The bench SHALL cover reset mid-burst: rst pulsed 1 cycle with m_valid = 1 -> m_valid = 0, busy = 0 next cycle; next grant goes to the lowest valid index.
REQ-032 The bench SHALL cover randomised valid/ready on all ports for 10k cycles -> per-requester output data order preserved, bursts never interleaved, every accepted beat seen exactly once.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// Four-way round-robin burst arbiter onto one valid/ready channel.
// A winner owns the channel until its last beat; a one-deep output stage gives full throughput.
module handshake_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int N      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        s_valid,
    input  logic [N*DATA_W-1:0] s_data,
    input  logic [N-1:0]        s_last,
    output logic [N-1:0]        s_ready,
    output logic                m_valid,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_last,
    output logic [1:0]          m_id,
    input  logic                m_ready,
    output logic                busy,
    output logic [1:0]          grant_id
);

    localparam int ID_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [ID_W-1:0]   grant_reg, grant_next;
    logic              m_valid_reg, m_valid_next;
    logic [DATA_W-1:0] m_data_reg, m_data_next;
    logic              m_last_reg, m_last_next;
    logic [ID_W-1:0]   m_id_reg, m_id_next;

    logic [DATA_W-1:0] lane_data [N];
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic              owner_ready;
    logic              xfer;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign lane_data[gi] = s_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Descending scan so the candidate closest to ptr (smallest offset) wins.
    always_comb begin : rr_search
        logic [ID_W-1:0] cand;
        cand      = ptr_reg;
        win_found = 1'b0;
        win_idx   = ptr_reg;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr_reg + ID_W'(k);
            if (s_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The owner may push whenever the output stage is empty or draining this cycle.
    assign owner_ready = ~m_valid_reg | m_ready;
    assign xfer        = (state_reg == LOCK) & s_valid[grant_reg] & owner_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign s_ready[gi] = ~rst & (state_reg == LOCK)
                               & (grant_reg == ID_W'(gi)) & owner_ready;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    grant_next = win_idx;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (xfer && s_last[grant_reg]) begin
                    state_next = IDLE;
                    ptr_next   = grant_reg + ID_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_last_next  = m_last_reg;
        m_id_next    = m_id_reg;
        if (xfer) begin
            m_valid_next = 1'b1;
            m_data_next  = lane_data[grant_reg];
            m_last_next  = s_last[grant_reg];
            m_id_next    = grant_reg;
        end else if (m_ready) begin
            m_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_last_reg  <= 1'b0;
            m_id_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            m_last_reg  <= m_last_next;
            m_id_reg    <= m_id_next;
        end
    end

    assign m_valid  = m_valid_reg;
    assign m_data   = m_data_reg;
    assign m_last   = m_last_reg;
    assign m_id     = m_id_reg;
    assign busy     = ~rst & (state_reg == LOCK);
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed and randomised checks for handshake_rr_arbiter with 8-bit payloads.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_handshake_rr_arbiter;

    localparam int DATA_W = 8;
    localparam int N      = 4;

    logic                clk;
    logic                rst;
    logic [N-1:0]        s_valid;
    logic [N*DATA_W-1:0] s_data;
    logic [N-1:0]        s_last;
    logic [N-1:0]        s_ready;
    logic                m_valid;
    logic [DATA_W-1:0]   m_data;
    logic                m_last;
    logic [1:0]          m_id;
    logic                m_ready;
    logic                busy;
    logic [1:0]          grant_id;

    int checks   = 0;
    int failures = 0;

    handshake_rr_arbiter #(.DATA_W(DATA_W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_id     (m_id),
        .m_ready  (m_ready),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DATA_W-1:0] v);
        s_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [DATA_W:0] exp_q [N][$];
    logic [DATA_W:0] exp_beat;
    int              seq [N];
    int              rem [N];
    int              beat;
    int              popped;
    bit              open_burst;
    logic [1:0]      open_owner;

    initial begin
        rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;

        // Reset values, during and after reset
        cyc();
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_m_valid", m_valid, 0);
        check("post_rst_m_data", m_data, 0);
        check("post_rst_m_last", m_last, 0);
        check("post_rst_m_id", m_id, 0);
        check("post_rst_grant", grant_id, 0);

        // Single requester, three-beat burst
        do_reset();
        s_valid = 4'b0100; set_lane(2, 8'hA0); s_last = 4'b0000; m_ready = 1'b1;
        @(negedge clk);
        check("single_t0_ready", s_ready, 4'b0000);
        check("single_t0_busy", busy, 0);
        cyc();
        @(negedge clk);
        check("single_t1_ready", s_ready, 4'b0100);
        check("single_t1_grant", grant_id, 2);
        check("single_t1_busy", busy, 1);
        check("single_t1_m_valid", m_valid, 0);
        cyc();
        set_lane(2, 8'hA1);
        @(negedge clk);
        $display("beat id=%0d data=0x%0h last=%0d", m_id, m_data, m_last);
        check("single_t2_m_valid", m_valid, 1);
        check("single_t2_data", m_data, 8'hA0);
        check("single_t2_id", m_id, 2);
        check("single_t2_last", m_last, 0);
        cyc();
        set_lane(2, 8'hA2); s_last = 4'b0100;
        @(negedge clk);
        $display("beat id=%0d data=0x%0h last=%0d", m_id, m_data, m_last);
        check("single_t3_data", m_data, 8'hA1);
        check("single_t3_last", m_last, 0);
        cyc();
        s_valid = '0; s_last = '0;
        @(negedge clk);
        $display("beat id=%0d data=0x%0h last=%0d", m_id, m_data, m_last);
        check("single_t4_data", m_data, 8'hA2);
        check("single_t4_last", m_last, 1);
        check("single_t4_busy", busy, 0);
        cyc();
        @(negedge clk);
        check("single_t5_m_valid", m_valid, 0);

        // Round robin of single-beat bursts from all four requesters
        do_reset();
        s_valid = 4'hF; s_last = 4'hF; m_ready = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 8'(8'h10 + i));
        @(negedge clk);
        check("rr_c0_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            check("rr_lock_m_valid", m_valid, 0);
            check("rr_lock_busy", busy, 1);
            check("rr_lock_grant", grant_id, k % 4);
            cyc();
            @(negedge clk);
            $display("beat id=%0d data=0x%0h last=%0d", m_id, m_data, m_last);
            check("rr_m_valid", m_valid, 1);
            check("rr_m_id", m_id, k % 4);
            check("rr_m_data", m_data, 8'h10 + (k % 4));
            check("rr_bubble_busy", busy, 0);
        end
        s_valid = '0;

        // Backpressure on a four-beat burst from requester 1
        do_reset();
        beat = 0; popped = 0;
        for (int c = 0; c < 16; c++) begin
            s_valid = (beat < 4) ? 4'b0010 : 4'b0000;
            set_lane(1, 8'(8'h30 + beat));
            s_last  = (beat == 3) ? 4'b0010 : 4'b0000;
            m_ready = !(c >= 2 && c <= 6);
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                check("bp_stall_m_valid", m_valid, 1);
                check("bp_stall_data", m_data, 8'h30);
                check("bp_stall_id", m_id, 1);
                check("bp_stall_s_ready", s_ready, 0);
            end
            if (m_valid && m_ready) begin
                $display("beat id=%0d data=0x%0h last=%0d", m_id, m_data, m_last);
                check("bp_data", m_data, 8'h30 + popped);
                check("bp_id", m_id, 1);
                check("bp_last", m_last, (popped == 3) ? 1 : 0);
                popped++;
            end
            if (s_valid[1] && s_ready[1]) beat++;
            cyc();
        end
        check("bp_beat_count", popped, 4);

        // Owner 3 pauses mid-burst while requester 0 waits
        do_reset();
        beat = 0; popped = 0; m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_valid[3] = (beat < 3) && !(c >= 3 && c <= 6);
            s_valid[0] = (c >= 2) && (c < 10);
            s_valid[2:1] = 2'b00;
            set_lane(3, 8'(8'h40 + beat));
            set_lane(0, 8'h50);
            s_last = {(beat == 2), 3'b001};
            @(negedge clk);
            if (c >= 2 && c <= 7) begin
                check("gap_grant", grant_id, 3);
                check("gap_busy", busy, 1);
                check("gap_s_ready0", s_ready[0], 0);
            end
            if (c == 8) check("gap_bubble_busy", busy, 0);
            if (c == 9) begin
                check("gap_next_grant", grant_id, 0);
                check("gap_next_busy", busy, 1);
            end
            if (c == 10) begin
                check("gap_next_m_id", m_id, 0);
                check("gap_next_m_data", m_data, 8'h50);
            end
            if (m_valid && m_ready && m_id == 2'd3) begin
                $display("beat id=%0d data=0x%0h last=%0d", m_id, m_data, m_last);
                check("gap_data", m_data, 8'h40 + popped);
                popped++;
            end
            if (s_valid[3] && s_ready[3]) beat++;
            cyc();
        end
        check("gap_beat_count", popped, 3);

        // Reset pulse with a beat pending; ptr is 1 beforehand
        s_valid = 4'b0100; s_last = 4'b0000; set_lane(2, 8'h60); m_ready = 1'b1;
        cyc();
        cyc();
        s_valid = 4'b1001; s_last = 4'b1001; rst = 1'b1;
        @(negedge clk);
        check("mrst_pending_m_valid", m_valid, 1);
        check("mrst_during_s_ready", s_ready, 0);
        check("mrst_during_busy", busy, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_after_m_valid", m_valid, 0);
        check("mrst_after_busy", busy, 0);
        check("mrst_after_s_ready", s_ready, 0);
        cyc();
        @(negedge clk);
        check("mrst_next_grant", grant_id, 0);
        check("mrst_next_busy", busy, 1);
        s_valid = '0; s_last = '0;

        // Randomised valid/ready with a per-requester scoreboard
        do_reset();
        open_burst = 1'b0; open_owner = 2'd0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            rem[i] = $urandom_range(1, 4);
        end
        for (int c = 0; c < 10010; c++) begin
            for (int i = 0; i < N; i++) begin
                s_valid[i] = (c < 10000) && ($urandom_range(0, 3) != 0);
                set_lane(i, {2'(i), 6'(seq[i])});
                s_last[i]  = (rem[i] == 1);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (s_valid[i] && s_ready[i]) begin
                    exp_q[i].push_back({s_last[i], s_data[i*DATA_W +: DATA_W]});
                    seq[i]++;
                    rem[i]--;
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                end
            end
            if (m_valid && m_ready) begin
                check("rnd_beat_expected", (exp_q[m_id].size() != 0), 1);
                if (exp_q[m_id].size() != 0) begin
                    exp_beat = exp_q[m_id].pop_front();
                    check("rnd_beat", {m_last, m_data}, exp_beat);
                end
                if (open_burst) check("rnd_interleave", m_id, open_owner);
                open_burst = !m_last;
                open_owner = m_id;
            end
            cyc();
        end
        for (int i = 0; i < N; i++) check("rnd_leftover", exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
